// File: rtl/tile_renderer.sv
// Scrolling tile-map renderer: composites player sprites over a RAM-backed map,
// flags collisions, coin pickups (with write-back), out-of-bounds and goal.
module tile_renderer #(
  parameter int unsigned TILE_BITS   = 4,
  parameter int unsigned MAP_W       = 300,
  parameter int unsigned MAP_H       = 54,
  parameter int unsigned H_ACT       = 1440,
  parameter int unsigned V_ACT       = 900,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SPR_SIZE    = 48,
  parameter logic [11:0] SKY_COL     = 12'h2CD,
  parameter logic [11:0] COIN_COL    = 12'hDD2,
  parameter logic [11:0] GOAL_COL    = 12'hF0E,
  parameter logic [11:0] BORDER_COL  = 12'hFFF,
  localparam int unsigned ADDR_W     = $clog2(MAP_W * MAP_H)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [10:0]               draw_x,
  input  logic [9:0]                draw_y,
  input  logic [11:0]               x_shift,
  input  logic [11*NUM_PLAYERS-1:0] spr_x,
  input  logic [10*NUM_PLAYERS-1:0] spr_y,
  input  logic [12*NUM_PLAYERS-1:0] spr_col,
  input  logic                      frame_ack,
  output logic [ADDR_W-1:0]         map_addr,
  output logic                      map_we,
  output logic [11:0]               map_wdata,
  input  logic [11:0]               map_rdata,
  output logic [3:0]                r_out,
  output logic [3:0]                g_out,
  output logic [3:0]                b_out,
  output logic [NUM_PLAYERS-1:0]    col_det,
  output logic [NUM_PLAYERS-1:0]    coin_det,
  output logic [NUM_PLAYERS-1:0]    outbounds,
  output logic                      game_win
);

  localparam int unsigned MAP_BOT = MAP_H << TILE_BITS;
  localparam int unsigned NP      = NUM_PLAYERS;

  localparam logic [1:0] RG_OFF    = 2'd0;
  localparam logic [1:0] RG_BORDER = 2'd1;
  localparam logic [1:0] RG_OFFMAP = 2'd2;
  localparam logic [1:0] RG_MAP    = 2'd3;

  // S0 combinational: tile address, region class and sprite hits
  logic [12:0]       sum_x_c;
  logic [12:0]       col_c;
  logic [9:0]        row_c;
  logic [ADDR_W-1:0] rd_addr_c;
  logic [1:0]        region_c;
  logic [NP-1:0]     hit_c;
  logic [11:0]       spr_rgb_c;
  logic [11:0]       sx_c;
  logic [11:0]       sy_c;

  // Pipeline and output registers
  logic              s1_valid_q,   s1_valid_d;
  logic              s1_stolen_q,  s1_stolen_d;
  logic [1:0]        s1_region_q,  s1_region_d;
  logic [NP-1:0]     s1_hit_q,     s1_hit_d;
  logic              s1_any_q,     s1_any_d;
  logic [11:0]       s1_spr_rgb_q, s1_spr_rgb_d;
  logic [ADDR_W-1:0] s1_addr_q,    s1_addr_d;
  logic [11:0]       rgb_q,        rgb_d;
  logic [NP-1:0]     col_det_q,    col_det_d;
  logic [NP-1:0]     coin_det_q,   coin_det_d;
  logic [NP-1:0]     outbounds_q,  outbounds_d;
  logic              game_win_q,   game_win_d;
  logic              map_we_q,     map_we_d;
  logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;
  logic [11:0]       map_wdata_q,  map_wdata_d;

  logic [11:0]       tile_c;
  logic [NP-1:0]     col_set_c;
  logic [NP-1:0]     coin_hit_c;
  logic              goal_c;
  logic              coin_wr_c;

  always_comb begin
    sum_x_c   = 13'(draw_x) + 13'(x_shift);
    col_c     = sum_x_c >> TILE_BITS;
    row_c     = draw_y >> TILE_BITS;
    rd_addr_c = ADDR_W'(20'(row_c) * 20'(MAP_W) + 20'(col_c));
    if (12'(draw_x) >= 12'(H_ACT) || 12'(draw_y) >= 12'(V_ACT)) begin
      region_c = RG_OFF;
    end else if (12'(draw_y) >= 12'(MAP_BOT)) begin
      region_c = RG_BORDER;
    end else if (col_c >= 13'(MAP_W)) begin
      region_c = RG_OFFMAP;
    end else begin
      region_c = RG_MAP;
    end
  end

  // Sprite hits; descending scan so the lowest-index player wins the colour
  always_comb begin
    hit_c     = '0;
    spr_rgb_c = '0;
    sx_c      = '0;
    sy_c      = '0;
    for (int i = 0; i < int'(NP); i++) begin
      sx_c     = 12'(spr_x[i*11 +: 11]);
      sy_c     = 12'(spr_y[i*10 +: 10]);
      hit_c[i] = (12'(draw_x) >= sx_c) && (12'(draw_x) < sx_c + 12'(SPR_SIZE)) &&
                 (12'(draw_y) >= sy_c) && (12'(draw_y) < sy_c + 12'(SPR_SIZE));
    end
    for (int i = int'(NP) - 1; i >= 0; i--) begin
      if (hit_c[i]) spr_rgb_c = spr_col[i*12 +: 12];
    end
  end

  // A pixel presented during a write cycle lost its read slot
  always_comb begin
    s1_valid_d   = 1'b1;
    s1_stolen_d  = map_we_q;
    s1_region_d  = region_c;
    s1_hit_d     = hit_c;
    s1_any_d     = |hit_c;
    s1_spr_rgb_d = spr_rgb_c;
    s1_addr_d    = rd_addr_c;
  end

  // S1: classify the tile and form the next rgb/flags/write
  always_comb begin
    case (s1_region_q)
      RG_MAP:    tile_c = map_rdata;
      RG_BORDER: tile_c = BORDER_COL;
      RG_OFFMAP: tile_c = SKY_COL;
      default:   tile_c = 12'h000;
    endcase
    rgb_d      = rgb_q;
    col_set_c  = '0;
    coin_hit_c = '0;
    goal_c     = 1'b0;
    coin_wr_c  = 1'b0;
    if (s1_valid_q && !s1_stolen_q) begin
      if (s1_region_q == RG_OFF)  rgb_d = 12'h000;
      else if (s1_any_q)          rgb_d = s1_spr_rgb_q;
      else                        rgb_d = tile_c;
      if (s1_region_q == RG_MAP) begin
        // A coin read while the previous write is in flight is stale
        if (map_rdata == COIN_COL) begin
          if (!map_we_q) begin
            coin_hit_c = s1_hit_q;
            coin_wr_c  = |s1_hit_q;
          end
        end else if (map_rdata == GOAL_COL) begin
          col_set_c = s1_hit_q;
          goal_c    = |s1_hit_q;
        end else if (map_rdata != SKY_COL) begin
          col_set_c = s1_hit_q;
        end
      end
    end
    col_det_d   = (col_det_q & ~{NP{frame_ack}}) | col_set_c;
    coin_det_d  = coin_hit_c;
    game_win_d  = game_win_q | goal_c;
    map_we_d    = coin_wr_c;
    wr_addr_d   = coin_wr_c ? s1_addr_q : wr_addr_q;
    map_wdata_d = coin_wr_c ? SKY_COL : map_wdata_q;
  end

  always_comb begin
    outbounds_d = '0;
    for (int i = 0; i < int'(NP); i++) begin
      outbounds_d[i] = (12'(spr_y[i*10 +: 10]) + 12'(SPR_SIZE)) >= 12'(MAP_BOT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_stolen_q  <= 1'b0;
      s1_region_q  <= RG_OFF;
      s1_hit_q     <= '0;
      s1_any_q     <= 1'b0;
      s1_spr_rgb_q <= '0;
      s1_addr_q    <= '0;
      rgb_q        <= '0;
      col_det_q    <= '0;
      coin_det_q   <= '0;
      outbounds_q  <= '0;
      game_win_q   <= 1'b0;
      map_we_q     <= 1'b0;
      wr_addr_q    <= '0;
      map_wdata_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_stolen_q  <= s1_stolen_d;
      s1_region_q  <= s1_region_d;
      s1_hit_q     <= s1_hit_d;
      s1_any_q     <= s1_any_d;
      s1_spr_rgb_q <= s1_spr_rgb_d;
      s1_addr_q    <= s1_addr_d;
      rgb_q        <= rgb_d;
      col_det_q    <= col_det_d;
      coin_det_q   <= coin_det_d;
      outbounds_q  <= outbounds_d;
      game_win_q   <= game_win_d;
      map_we_q     <= map_we_d;
      wr_addr_q    <= wr_addr_d;
      map_wdata_q  <= map_wdata_d;
    end
  end

  // The RAM address must be combinational to meet the 2-cycle latency
  always_comb begin
    map_addr = rd_addr_c;
    if (rst)           map_addr = '0;
    else if (map_we_q) map_addr = wr_addr_q;
  end

  assign map_we    = map_we_q;
  assign map_wdata = map_wdata_q;
  assign r_out     = rgb_q[11:8];
  assign g_out     = rgb_q[7:4];
  assign b_out     = rgb_q[3:0];
  assign col_det   = col_det_q;
  assign coin_det  = coin_det_q;
  assign outbounds = outbounds_q;
  assign game_win  = game_win_q;

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer with a behavioural single-port map RAM.
module tb_tile_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] draw_x;
  logic [9:0]  draw_y;
  logic [11:0] x_shift;
  logic [21:0] spr_x;
  logic [19:0] spr_y;
  logic [23:0] spr_col;
  logic        frame_ack;
  logic [13:0] map_addr;
  logic        map_we;
  logic [11:0] map_wdata;
  logic [11:0] map_rdata;
  logic [3:0]  r_out, g_out, b_out;
  logic [1:0]  col_det, coin_det, outbounds;
  logic        game_win;

  logic        tb_fill, tb_we;
  logic [13:0] tb_addr;
  logic [11:0] tb_wdata;
  logic [11:0] mem [0:16199];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_renderer dut (
    .clk(clk), .rst(rst), .draw_x(draw_x), .draw_y(draw_y), .x_shift(x_shift),
    .spr_x(spr_x), .spr_y(spr_y), .spr_col(spr_col), .frame_ack(frame_ack),
    .map_addr(map_addr), .map_we(map_we), .map_wdata(map_wdata), .map_rdata(map_rdata),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .col_det(col_det),
    .coin_det(coin_det), .outbounds(outbounds), .game_win(game_win)
  );

  // Synchronous-read map RAM with a bench-side fill/preload port
  always @(posedge clk) begin
    if (tb_fill) begin
      for (int i = 0; i < 16200; i++) mem[i] <= 12'h2CD;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_wdata;
    end else if (map_we && int'(map_addr) < 16200) begin
      mem[map_addr] <= map_wdata;
    end
    map_rdata <= (int'(map_addr) < 16200) ? mem[map_addr] : 12'h000;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input int x, input int y);
    draw_x = 11'(x);
    draw_y = 10'(y);
  endtask

  task automatic set_spr(input int p, input int x, input int y, input logic [11:0] c);
    spr_x[p*11 +: 11] = 11'(x);
    spr_y[p*10 +: 10] = 10'(y);
    spr_col[p*12 +: 12] = c;
  endtask

  task automatic load(input int a, input logic [11:0] d);
    tb_we    = 1'b1;
    tb_addr  = 14'(a);
    tb_wdata = d;
    cyc();
    tb_we    = 1'b0;
  endtask

  function automatic logic [31:0] rgb();
    return 32'({r_out, g_out, b_out});
  endfunction

  initial begin
    rst = 1'b1; tb_fill = 1'b1; tb_we = 1'b0; tb_addr = '0; tb_wdata = '0;
    frame_ack = 1'b0; x_shift = '0; spr_x = '0; spr_y = '0; spr_col = '0;
    pix(700, 5);
    set_spr(0, 2000, 1000, 12'h000);
    set_spr(1, 2000, 1000, 12'h000);
    cyc();
    tb_fill = 1'b0;
    load(0,    12'h123);
    load(1,    12'h456);
    load(62,   12'h222);
    load(318,  12'h111);
    load(6020, 12'hDD2);
    load(6021, 12'hDD2);
    load(7530, 12'h840);
    load(9040, 12'hF0E);

    // Reset held mid-line
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("rst_rgb", rgb(), 32'h0);
      chk("rst_flags", 32'({col_det, coin_det, outbounds, game_win}), 32'h0);
      chk("rst_map", 32'({map_we, map_addr}), 32'h0);
    end

    rst = 1'b0;
    pix(5, 5);
    cyc(); chk("lat1_rgb", rgb(), 32'h000);
    cyc(); chk("tile00", rgb(), 32'h123);
    x_shift = 12'd16;
    cyc(); cyc(); chk("tile01_shift", rgb(), 32'h456);
    x_shift = 12'd0;
    pix(5, 870);  cyc(); cyc(); chk("border870", rgb(), 32'hFFF);
    pix(5, 863);  cyc(); cyc(); chk("lastrow863", rgb(), 32'h2CD);
    pix(1440, 5); cyc(); cyc(); chk("x1440_off", rgb(), 32'h000);
    pix(1439, 5); cyc(); cyc(); chk("x1439_on", rgb(), 32'h2CD);
    pix(1000, 0); x_shift = 12'd4095;
    cyc(); cyc(); chk("col_offmap", rgb(), 32'h2CD);
    x_shift = 12'd0;
    chk("no_flags", 32'({col_det, coin_det, game_win}), 32'h0);

    // Sprite compositing
    set_spr(0, 100, 100, 12'h800);
    set_spr(1, 110, 100, 12'h080);
    pix(120, 120); cyc(); cyc(); chk("spr_overlap", rgb(), 32'h800);
    pix(147, 120); cyc(); cyc(); chk("spr0_edge", rgb(), 32'h800);
    pix(148, 120); cyc(); cyc(); chk("spr1_only148", rgb(), 32'h080);
    pix(150, 120); cyc(); cyc(); chk("spr1_only150", rgb(), 32'h080);
    pix(158, 120); cyc(); cyc(); chk("spr1_xend", rgb(), 32'h2CD);
    pix(120, 148); cyc(); cyc(); chk("spr_yend", rgb(), 32'h2CD);
    chk("spr_sky_flags", 32'({col_det, coin_det}), 32'h0);

    // Coin pickup, write-back and stolen slot
    set_spr(1, 2000, 1000, 12'h000);
    set_spr(0, 300, 300, 12'h800);
    pix(320, 320); cyc();
    chk("coin_pre", 32'({coin_det, map_we}), 32'h0);
    pix(5, 5); cyc();
    chk("coin_rgb", rgb(), 32'h800);
    chk("coin_det", 32'(coin_det), 32'h1);
    chk("coin_we", 32'(map_we), 32'h1);
    chk("coin_addr", 32'(map_addr), 32'd6020);
    chk("coin_wdata", 32'(map_wdata), 32'h2CD);
    pix(20, 5); cyc();
    chk("after_rgb", rgb(), 32'h123);
    chk("after_flags", 32'({coin_det, map_we}), 32'h0);
    cyc(); chk("stolen_rgb", rgb(), 32'h123);
    cyc(); chk("post_stolen_rgb", rgb(), 32'h456);
    pix(320, 320);
    for (int k = 0; k < 4; k++) begin
      cyc(); chk("coin_once", 32'({coin_det, map_we}), 32'h0);
    end
    chk("coin_spr_rgb", rgb(), 32'h800);
    set_spr(0, 2000, 1000, 12'h000);
    cyc(); cyc(); chk("coin_cleared", rgb(), 32'h2CD);

    // Brick collision, sticky until frame_ack, set wins over ack
    set_spr(1, 470, 390, 12'h080);
    pix(485, 405); cyc(); cyc();
    chk("brick_col", 32'(col_det), 32'h2);
    chk("brick_rgb", rgb(), 32'h080);
    pix(485, 600); cyc(); cyc(); cyc();
    chk("brick_sticky", 32'(col_det), 32'h2);
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    chk("brick_ack", 32'(col_det), 32'h0);
    pix(485, 405); cyc();
    frame_ack = 1'b1; pix(485, 600); cyc(); frame_ack = 1'b0;
    chk("set_wins", 32'(col_det), 32'h2);
    cyc(); chk("set_wins_hold", 32'(col_det), 32'h2);
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    chk("brick_ack2", 32'(col_det), 32'h0);

    // Goal
    set_spr(1, 2000, 1000, 12'h000);
    set_spr(0, 630, 470, 12'h800);
    pix(645, 485); cyc(); cyc();
    chk("goal_win", 32'(game_win), 32'h1);
    chk("goal_col", 32'(col_det), 32'h1);
    pix(645, 600); cyc(); cyc();
    frame_ack = 1'b1; cyc(); frame_ack = 1'b0;
    chk("goal_ack_col", 32'(col_det), 32'h0);
    chk("goal_ack_win", 32'(game_win), 32'h1);
    cyc(); chk("goal_hold", 32'(game_win), 32'h1);

    // Out of bounds threshold
    set_spr(0, 630, 816, 12'h800);
    cyc(); chk("oob_816", 32'(outbounds), 32'h3);
    set_spr(0, 630, 815, 12'h800);
    cyc(); chk("oob_815", 32'(outbounds), 32'h2);

    rst = 1'b1; cyc();
    chk("rst_win", 32'({game_win, outbounds}), 32'h0);

    // Reset drops a pending coin write
    rst = 1'b0;
    set_spr(0, 300, 300, 12'h800);
    pix(340, 320); cyc();
    rst = 1'b1; cyc();
    chk("rst_drop", 32'({coin_det, map_we}), 32'h0);
    rst = 1'b0; cyc();
    chk("rst_nowrite", 32'({coin_det, map_we}), 32'h0);
    cyc();
    chk("coin2_det", 32'(coin_det), 32'h1);
    chk("coin2_we", 32'(map_we), 32'h1);
    chk("coin2_addr", 32'(map_addr), 32'd6021);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
